// File: rtl/dac_pkg.sv
// rtl/dac_pkg.sv - shared state encoding and default widths for the DAC playback path
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_TICK = 2'd2
  } dac_state_e;

  localparam int DAC_SRAM_AW          = 18;
  localparam int DAC_PERIOD_W         = 16;
  localparam int DAC_COUNT_W          = 16;
  localparam int DAC_WORDS_PER_UPDATE = 2;

endpackage

// File: rtl/dac_period_timer.sv
// rtl/dac_period_timer.sv - update tick source; DAC_EXT_TRIG_EN swaps the down-counter for a trigger edge detector
module dac_period_timer #(
  parameter int PERIOD_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic [PERIOD_WIDTH-1:0] reload_i,
`ifdef DAC_EXT_TRIG_EN
  input  logic                    trig_i,
`endif
  output logic                    tick_o
);

`ifdef DAC_EXT_TRIG_EN
  // [0] metastable stage, [1] synchronised level, [2] previous level
  logic [2:0] sync_q;
  logic       unused_cfg;

  assign unused_cfg = ^{load_i, reload_i};

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], trig_i};
  end

  assign tick_o = en_i && sync_q[1] && !sync_q[2];
`else
  logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d, rld_q, rld_d;

  always_comb begin
    cnt_d = cnt_q;
    rld_d = rld_q;
    if (load_i) begin
      cnt_d = reload_i;
      rld_d = reload_i;
    end else if (en_i) begin
      cnt_d = (cnt_q == '0) ? rld_q : cnt_q - PERIOD_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      rld_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rld_q <= rld_d;
    end
  end

  assign tick_o = en_i && (cnt_q == '0);
`endif

endmodule

// File: rtl/dac_playback_sched.sv
// rtl/dac_playback_sched.sv - periodic DAC update request scheduler; DAC_EXT_TRIG_EN adds trig_i
module dac_playback_sched
  import dac_pkg::*;
#(
  parameter int SRAM_ADDRESS_WIDTH = DAC_SRAM_AW,
  parameter int PERIOD_WIDTH       = DAC_PERIOD_W,
  parameter int COUNT_WIDTH        = DAC_COUNT_W,
  parameter int WORDS_PER_UPDATE   = DAC_WORDS_PER_UPDATE
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_n_i,
  input  logic                          cfg_start_i,
  input  logic                          cfg_stop_i,
  input  logic [SRAM_ADDRESS_WIDTH-1:0] cfg_base_i,
  input  logic [COUNT_WIDTH-1:0]        cfg_count_i,
  input  logic [PERIOD_WIDTH-1:0]       cfg_period_i,
  input  logic                          cfg_loop_i,
`ifdef DAC_EXT_TRIG_EN
  input  logic                          trig_i,
`endif
  output logic                          upd_cyc_o,
  output logic                          upd_stb_o,
  output logic [SRAM_ADDRESS_WIDTH-1:0] upd_adr_o,
  input  logic                          upd_ack_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          underrun_o,
  output logic [COUNT_WIDTH-1:0]        upd_index_o
);

  dac_state_e                    state_q, state_d;
  logic [SRAM_ADDRESS_WIDTH-1:0] base_q, base_d, adr_q, adr_d;
  logic [COUNT_WIDTH-1:0]        count_q, count_d, idx_q, idx_d;
  logic                          loop_q, loop_d, pend_q, pend_d, stop_q, stop_d;
  logic                          und_q, und_d, done_q, done_d;
  logic                          accept, tick, last;
  logic [PERIOD_WIDTH-1:0]       reload;

  assign accept = (state_q == ST_IDLE) && cfg_start_i && !cfg_stop_i;
  assign reload = (cfg_period_i == '0) ? '0 : cfg_period_i - PERIOD_WIDTH'(1);
  assign last   = (idx_q == count_q - COUNT_WIDTH'(1));

  dac_period_timer #(.PERIOD_WIDTH(PERIOD_WIDTH)) u_timer (
    .clk_i    (wb_clk_i),
    .rst_n_i  (wb_rst_n_i),
    .load_i   (accept),
    .en_i     (state_q != ST_IDLE),
    .reload_i (reload),
`ifdef DAC_EXT_TRIG_EN
    .trig_i   (trig_i),
`endif
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    count_d = count_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    adr_d   = adr_q;
    pend_d  = pend_q;
    stop_d  = stop_q;
    und_d   = und_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d  = cfg_base_i;
          count_d = cfg_count_i;
          loop_d  = cfg_loop_i;
          idx_d   = '0;
          adr_d   = cfg_base_i;
          pend_d  = 1'b0;
          stop_d  = 1'b0;
          und_d   = 1'b0;
          if (cfg_count_i != '0) state_d = ST_ISSUE;
          else                   done_d  = 1'b1;
        end
      end
      ST_ISSUE: begin
        // A tick in the ack cycle still counts as overlapping the in-flight update
        if (tick)       und_d  = 1'b1;
        if (cfg_stop_i) stop_d = 1'b1;
        if (upd_ack_i) begin
          pend_d = 1'b0;
          if (last && loop_q) begin
            idx_d = '0;
            adr_d = base_q;
          end else begin
            idx_d = idx_q + COUNT_WIDTH'(1);
            adr_d = adr_q + SRAM_ADDRESS_WIDTH'(WORDS_PER_UPDATE);
          end
          if (stop_q || cfg_stop_i || (last && !loop_q)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (pend_q || tick) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT_TICK;
          end
        end else if (tick) begin
          pend_d = 1'b1;
        end
      end
      ST_WAIT_TICK: begin
        if (cfg_stop_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (tick) begin
          state_d = ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      count_q <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      adr_q   <= '0;
      pend_q  <= 1'b0;
      stop_q  <= 1'b0;
      und_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      adr_q   <= adr_d;
      pend_q  <= pend_d;
      stop_q  <= stop_d;
      und_q   <= und_d;
      done_q  <= done_d;
    end
  end

  assign upd_cyc_o   = (state_q == ST_ISSUE);
  assign upd_stb_o   = upd_cyc_o;
  assign upd_adr_o   = adr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign underrun_o  = und_q;
  assign upd_index_o = idx_q;

endmodule

// File: tb/tb_dac_playback_sched.sv
// tb/tb_dac_playback_sched.sv - self-checking bench for dac_playback_sched (DAC_EXT_TRIG_EN aware)
module tb_dac_playback_sched;

  localparam int AW = 18;
  localparam int PW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n, start, stop, loop_c, ack;
  logic [AW-1:0] base;
  logic [CW-1:0] count;
  logic [PW-1:0] period;
  logic          upd_cyc_o, upd_stb_o, busy_o, done_o, underrun_o;
  logic [AW-1:0] upd_adr_o;
  logic [CW-1:0] upd_index_o;
`ifdef DAC_EXT_TRIG_EN
  logic          trig;
`endif

  always #5 clk = ~clk;

  dac_playback_sched dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .cfg_start_i  (start),
    .cfg_stop_i   (stop),
    .cfg_base_i   (base),
    .cfg_count_i  (count),
    .cfg_period_i (period),
    .cfg_loop_i   (loop_c),
`ifdef DAC_EXT_TRIG_EN
    .trig_i       (trig),
`endif
    .upd_cyc_o    (upd_cyc_o),
    .upd_stb_o    (upd_stb_o),
    .upd_adr_o    (upd_adr_o),
    .upd_ack_i    (ack),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .underrun_o   (underrun_o),
    .upd_index_o  (upd_index_o)
  );

  int            n_pass = 0;
  int            n_total = 0;
  int            ot[$];
  logic [AW-1:0] oa[$];
  int            oi[$];
  int            done_c;
  bit            quiet;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Tick schedule seen by the scheduler, in cycles after the start cycle
  function automatic bit is_tick(input int c, input int p);
`ifdef DAC_EXT_TRIG_EN
    return (p >= 0) && (c >= 22) && ((c - 22) % 50 == 0);
`else
    return (c % p) == 0;
`endif
  endfunction

  task automatic run(input logic [AW-1:0] b, input int cnt, input int per, input bit lp,
                     input int lat, input int stop_req, input string tag);
    int            et[$];
    logic [AW-1:0] ea[$];
    int            ei[$];
    int            edone, p, t, j, a, c, rs;
    bit            eund, tk, in_req, stable;
    logic [AW-1:0] cur_adr;

    // reference: one request per issue, next issue right after ack if a tick overlapped it
    p = (per == 0) ? 1 : per;
    t = 1; j = 0; eund = 0; edone = 1;
    if (cnt != 0) forever begin
      et.push_back(t);
      ea.push_back(AW'(int'(b) + 2 * (j % cnt)));
      ei.push_back(j % cnt);
      a = t + lat;
      tk = 0;
      for (int k = t; k <= a; k++) if (is_tick(k, p)) tk = 1;
      if (tk) eund = 1;
      if (stop_req == j || (!lp && j + 1 == cnt)) begin
        edone = a + 1;
        break;
      end
      j++;
      t = a + 1;
      if (!tk) begin
        while (!is_tick(t, p)) t++;
        t++;
      end
    end

    ot.delete(); oa.delete(); oi.delete();
    @(negedge clk);
    base = b; count = CW'(cnt); period = PW'(per); loop_c = lp;
    start = 1; stop = 0; ack = 0;
    c = 0; in_req = 0; rs = 0; done_c = -1; stable = 1; cur_adr = '0;
    while (c < 600 && done_c < 0) begin
      @(negedge clk);
      c++;
      start = (c == 2 && cnt != 0);
      stop = 0; ack = 0;
`ifdef DAC_EXT_TRIG_EN
      trig = (c >= 20) && ((c - 20) % 50 < 5);
`endif
      if (done_o) done_c = c;
      if (upd_cyc_o && !in_req) begin
        ot.push_back(c); oa.push_back(upd_adr_o); oi.push_back(int'(upd_index_o));
        in_req = 1; rs = c; cur_adr = upd_adr_o;
        if (upd_stb_o !== 1'b1) stable = 0;
      end else if (in_req && (upd_adr_o !== cur_adr || upd_cyc_o !== 1'b1 || upd_stb_o !== 1'b1)) begin
        stable = 0;
      end
      if (in_req && c == rs + 1 && ot.size() - 1 == stop_req) stop = 1;
      if (in_req && c == rs + lat) begin
        ack = 1;
        in_req = 0;
      end
    end
    start = 0; stop = 0; ack = 0;
`ifdef DAC_EXT_TRIG_EN
    trig = 0;
`endif
    check({tag, "_underrun"}, underrun_o, eund);
    quiet = 1;
    repeat (3) begin
      @(negedge clk);
      if (upd_cyc_o || busy_o || done_o) quiet = 0;
    end
    check({tag, "_issues"}, ot.size(), et.size());
    foreach (et[i]) begin
      if (i < ot.size()) begin
        check($sformatf("%s_t%0d", tag, i), ot[i], et[i]);
        check($sformatf("%s_adr%0d", tag, i), oa[i], ea[i]);
        check($sformatf("%s_idx%0d", tag, i), oi[i], ei[i]);
      end
    end
    check({tag, "_done"}, done_c, edone);
    check({tag, "_hold"}, stable, 1);
    check({tag, "_quiet"}, quiet, 1);
  endtask

  initial begin
    int lp, cnt, per, lat, sreq;
    rst_n = 0; start = 0; stop = 0; ack = 0; loop_c = 0;
    base = '0; count = '0; period = '0;
`ifdef DAC_EXT_TRIG_EN
    trig = 0;
`endif
    repeat (2) @(negedge clk);
    check("rst_cyc", upd_cyc_o, 0);
    check("rst_stb", upd_stb_o, 0);
    check("rst_adr", upd_adr_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_underrun", underrun_o, 0);
    check("rst_index", upd_index_o, 0);
    rst_n = 1;

`ifndef DAC_EXT_TRIG_EN
    run(18'h100, 3, 10, 0, 2, -1, "basic");
    check("basic_t0", ot[0], 1);
    check("basic_t1", ot[1], 11);
    check("basic_t2", ot[2], 21);
    check("basic_a2", oa[2], 18'h104);
    check("basic_donecyc", done_c, 24);

    run(18'h100, 2, 10, 1, 2, 2, "loopstop");
    check("loopstop_a2", oa[2], 18'h100);

    run(18'h100, 2, 4, 0, 9, -1, "under");
    check("under_t1", ot[1], 11);

    run(18'h3FFFF, 2, 5, 0, 3, -1, "wrap");
    check("wrap_a1", oa[1], 18'h00001);

    run(18'h200, 0, 5, 0, 2, -1, "zero");
    check("zero_donecyc", done_c, 1);
`else
    run(18'h100, 3, 3, 0, 2, -1, "ext");
    check("ext_t1", ot[1], 23);
    check("ext_t2", ot[2], 73);
`endif

    @(negedge clk);
    base = 18'h80; count = 3; period = 5; loop_c = 0; start = 1; stop = 1;
    @(negedge clk);
    start = 0; stop = 0;
    quiet = 1;
    repeat (4) begin
      if (upd_cyc_o || done_o || busy_o) quiet = 0;
      @(negedge clk);
    end
    check("startstop_quiet", quiet, 1);

    base = 18'h40; count = 3; period = 1; loop_c = 0; start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    check("mid_cyc", upd_cyc_o, 1);
`ifndef DAC_EXT_TRIG_EN
    check("mid_underrun", underrun_o, 1);
`endif
    #2 rst_n = 0;
    #1;
    check("arst_cyc", upd_cyc_o, 0);
    check("arst_stb", upd_stb_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_underrun", underrun_o, 0);
    check("arst_index", upd_index_o, 0);
    check("arst_adr", upd_adr_o, 0);
    @(negedge clk);
    rst_n = 1;
    run(18'h40, 2, 6, 0, 3, -1, "after_rst");

    for (int it = 0; it < 10; it++) begin
      lp  = int'($urandom_range(0, 1));
      cnt = int'($urandom_range(1, 4));
      per = int'($urandom_range(0, 12));
      lat = int'($urandom_range(1, 14));
      if (lp != 0)                       sreq = int'($urandom_range(0, 5));
      else if ($urandom_range(0, 2) == 0) sreq = int'($urandom_range(0, cnt - 1));
      else                                sreq = -1;
      run(AW'($urandom), cnt, per, lp[0], lat, sreq, $sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
